pipeline_stage_regs: RTL and testbench

//  Three pipeline latches of the 5-stage processor, in one block:
//    F/D (PC+1, instruction), D/X (instruction, PC, regfile A/B), M/W (instruction, ALU/address O, dmem data D).

---
 rtl/pipeline_stage_regs_pkg.sv | 9 +
 rtl/stage_reg.sv | 39 +++
 rtl/pipeline_stage_regs.sv | 87 ++++++++
 tb/tb_pipeline_stage_regs.sv | 163 ++++++++++++++++
 4 files changed

// File: rtl/pipeline_stage_regs_pkg.sv
// Shared constants for the pipeline latches and the decode/bypass logic.
//   DataW    : datapath width of every pipeline field (IR, PC, A, B, O, D)
//   NopInstr : instruction word loaded on reset and on bubble insertion
package pipeline_stage_regs_pkg;

    localparam int unsigned DataW = 32;
    localparam logic [DataW-1:0] NopInstr = '0;

endpackage

// File: rtl/stage_reg.sv
// Enable register with synchronous active-high reset. One instance holds one pipeline field.
// Ports:
//   clock : rising-edge clock
//   reset : synchronous, active-high; loads RstVal
//   en    : load enable (0 = hold)
//   d     : next value
//   q     : registered value
module stage_reg #(
    parameter int unsigned W      = 32,
    parameter logic [W-1:0] RstVal = '0
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         en,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] q_d;
    logic [W-1:0] q_q;

    always_comb begin
        q_d = q_q;
        if (en) begin
            q_d = d;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            q_q <= RstVal;
        end else begin
            q_q <= q_d;
        end
    end

    assign q = q_q;

endmodule

// File: rtl/pipeline_stage_regs.sv
// F/D, D/X and M/W pipeline latches of the 5-stage processor. Each field is a flop with its own
// stage enable; D/X can inject a NOP instruction (bubble) while still loading PC/A/B.
// Ports:
//   clock, reset                     : rising-edge clock, synchronous active-high reset
//   fd_en, fd_ir_in, fd_pc_in        : F/D enable and inputs  -> fd_ir, fd_pc
//   dx_en, dx_bubble, dx_*_in        : D/X enable, bubble and inputs -> dx_ir, dx_pc, dx_a, dx_b
//   mw_en, mw_ir_in, mw_o_in, mw_d_in: M/W enable and inputs -> mw_ir, mw_o, mw_d
// All outputs come straight from flops.
module pipeline_stage_regs
    import pipeline_stage_regs_pkg::*;
#(
    parameter int unsigned  W   = DataW,
    parameter logic [W-1:0] NOP = NopInstr
) (
    input  logic         clock,
    input  logic         reset,
    // F/D
    input  logic         fd_en,
    input  logic [W-1:0] fd_ir_in,
    input  logic [W-1:0] fd_pc_in,
    output logic [W-1:0] fd_ir,
    output logic [W-1:0] fd_pc,
    // D/X
    input  logic         dx_en,
    input  logic         dx_bubble,
    input  logic [W-1:0] dx_ir_in,
    input  logic [W-1:0] dx_pc_in,
    input  logic [W-1:0] dx_a_in,
    input  logic [W-1:0] dx_b_in,
    output logic [W-1:0] dx_ir,
    output logic [W-1:0] dx_pc,
    output logic [W-1:0] dx_a,
    output logic [W-1:0] dx_b,
    // M/W
    input  logic         mw_en,
    input  logic [W-1:0] mw_ir_in,
    input  logic [W-1:0] mw_o_in,
    input  logic [W-1:0] mw_d_in,
    output logic [W-1:0] mw_ir,
    output logic [W-1:0] mw_o,
    output logic [W-1:0] mw_d
);

    // Bubble only replaces the instruction; operands and PC still advance.
    logic [W-1:0] dx_ir_d;

    always_comb begin
        dx_ir_d = dx_ir_in;
        if (dx_bubble) begin
            dx_ir_d = NOP;
        end
    end

    // F/D
    stage_reg #(.W(W), .RstVal(NOP)) u_fd_ir (
        .clock(clock), .reset(reset), .en(fd_en), .d(fd_ir_in), .q(fd_ir)
    );
    stage_reg #(.W(W)) u_fd_pc (
        .clock(clock), .reset(reset), .en(fd_en), .d(fd_pc_in), .q(fd_pc)
    );

    // D/X
    stage_reg #(.W(W), .RstVal(NOP)) u_dx_ir (
        .clock(clock), .reset(reset), .en(dx_en), .d(dx_ir_d), .q(dx_ir)
    );
    stage_reg #(.W(W)) u_dx_pc (
        .clock(clock), .reset(reset), .en(dx_en), .d(dx_pc_in), .q(dx_pc)
    );
    stage_reg #(.W(W)) u_dx_a (
        .clock(clock), .reset(reset), .en(dx_en), .d(dx_a_in), .q(dx_a)
    );
    stage_reg #(.W(W)) u_dx_b (
        .clock(clock), .reset(reset), .en(dx_en), .d(dx_b_in), .q(dx_b)
    );

    // M/W
    stage_reg #(.W(W), .RstVal(NOP)) u_mw_ir (
        .clock(clock), .reset(reset), .en(mw_en), .d(mw_ir_in), .q(mw_ir)
    );
    stage_reg #(.W(W)) u_mw_o (
        .clock(clock), .reset(reset), .en(mw_en), .d(mw_o_in), .q(mw_o)
    );
    stage_reg #(.W(W)) u_mw_d (
        .clock(clock), .reset(reset), .en(mw_en), .d(mw_d_in), .q(mw_d)
    );

endmodule

// File: tb/tb_pipeline_stage_regs.sv
// Bench for pipeline_stage_regs: directed vectors with literal expectations, plus a
// per-cycle comparison of all nine outputs against a field-array model.
module tb_pipeline_stage_regs;

    localparam int unsigned W = 32;
    localparam int NF = 9;

    logic         clock = 1'b0;
    logic         reset;
    logic         fd_en, dx_en, dx_bubble, mw_en;
    logic [W-1:0] fd_ir_in, fd_pc_in;
    logic [W-1:0] dx_ir_in, dx_pc_in, dx_a_in, dx_b_in;
    logic [W-1:0] mw_ir_in, mw_o_in, mw_d_in;
    logic [W-1:0] fd_ir, fd_pc, dx_ir, dx_pc, dx_a, dx_b, mw_ir, mw_o, mw_d;

    int checks = 0;
    int errors = 0;

    pipeline_stage_regs dut (
        .clock(clock), .reset(reset),
        .fd_en(fd_en), .fd_ir_in(fd_ir_in), .fd_pc_in(fd_pc_in), .fd_ir(fd_ir), .fd_pc(fd_pc),
        .dx_en(dx_en), .dx_bubble(dx_bubble), .dx_ir_in(dx_ir_in), .dx_pc_in(dx_pc_in),
        .dx_a_in(dx_a_in), .dx_b_in(dx_b_in), .dx_ir(dx_ir), .dx_pc(dx_pc), .dx_a(dx_a),
        .dx_b(dx_b),
        .mw_en(mw_en), .mw_ir_in(mw_ir_in), .mw_o_in(mw_o_in), .mw_d_in(mw_d_in),
        .mw_ir(mw_ir), .mw_o(mw_o), .mw_d(mw_d)
    );

    always #5 clock = ~clock;

    // Model: fields 0..8 = fd_ir, fd_pc, dx_ir, dx_pc, dx_a, dx_b, mw_ir, mw_o, mw_d.
    // Stage of each field: 0 = F/D, 1 = D/X, 2 = M/W.
    logic [W-1:0] model [NF];
    bit model_valid = 1'b0;
    string fname [NF] = '{"fd_ir", "fd_pc", "dx_ir", "dx_pc", "dx_a", "dx_b",
                          "mw_ir", "mw_o", "mw_d"};
    int stage_of [NF] = '{0, 0, 1, 1, 1, 1, 2, 2, 2};

    always @(posedge clock) begin
        logic [W-1:0] in_v [NF];
        bit en_v [3];
        in_v = '{fd_ir_in, fd_pc_in, dx_bubble ? 32'h0 : dx_ir_in, dx_pc_in, dx_a_in, dx_b_in,
                 mw_ir_in, mw_o_in, mw_d_in};
        en_v = '{fd_en, dx_en, mw_en};
        for (int i = 0; i < NF; i++) begin
            if (reset) model[i] <= '0;
            else if (en_v[stage_of[i]]) model[i] <= in_v[i];
        end
        if (reset) model_valid <= 1'b1;
    end

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle compare away from the active edge.
    always @(negedge clock) begin
        logic [W-1:0] act [NF];
        act = '{fd_ir, fd_pc, dx_ir, dx_pc, dx_a, dx_b, mw_ir, mw_o, mw_d};
        if (model_valid) begin
            for (int i = 0; i < NF; i++) chk({"model_", fname[i]}, act[i], model[i]);
        end
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic set_all(input logic [W-1:0] v);
        fd_ir_in = v; fd_pc_in = v;
        dx_ir_in = v; dx_pc_in = v; dx_a_in = v; dx_b_in = v;
        mw_ir_in = v; mw_o_in = v; mw_d_in = v;
    endtask

    initial begin
        // Reset with every input all-ones and every enable high.
        set_all(32'hFFFF_FFFF);
        fd_en = 1; dx_en = 1; mw_en = 1; dx_bubble = 0; reset = 1;
        step();
        chk("rst_fd_ir", fd_ir, 32'h0); chk("rst_fd_pc", fd_pc, 32'h0);
        chk("rst_dx_ir", dx_ir, 32'h0); chk("rst_dx_pc", dx_pc, 32'h0);
        chk("rst_dx_a", dx_a, 32'h0);   chk("rst_dx_b", dx_b, 32'h0);
        chk("rst_mw_ir", mw_ir, 32'h0); chk("rst_mw_o", mw_o, 32'h0);
        chk("rst_mw_d", mw_d, 32'h0);

        // F/D pass-through.
        reset = 0; fd_ir_in = 32'h2842_0005; fd_pc_in = 7;
        step();
        chk("pass_fd_ir", fd_ir, 32'h2842_0005); chk("pass_fd_pc", fd_pc, 32'd7);

        // F/D stall.
        fd_ir_in = 32'h1234_5678; fd_pc_in = 8;
        step();
        chk("load_fd_ir", fd_ir, 32'h1234_5678);
        fd_en = 0; fd_ir_in = 32'hDEAD_BEEF; fd_pc_in = 9;
        for (int k = 0; k < 3; k++) begin
            step();
            chk("stall_fd_ir", fd_ir, 32'h1234_5678);
            chk("stall_fd_pc", fd_pc, 32'd8);
        end

        // Load-use pattern: F/D frozen, nop injected into D/X.
        dx_en = 1; dx_bubble = 1; dx_ir_in = 32'h4000_0003; dx_pc_in = 5;
        dx_a_in = 9; dx_b_in = 11;
        step();
        chk("bub_dx_ir", dx_ir, 32'h0); chk("bub_dx_a", dx_a, 32'd9);
        chk("bub_dx_pc", dx_pc, 32'd5); chk("bub_dx_b", dx_b, 32'd11);
        chk("bub_fd_ir", fd_ir, 32'h1234_5678);

        // D/X load, then hold with bubble ignored.
        dx_bubble = 0; dx_ir_in = 32'hAAAA_AAAA; dx_pc_in = 32'hAAAA_AAAA;
        dx_a_in = 32'hAAAA_AAAA; dx_b_in = 32'hAAAA_AAAA;
        step();
        chk("dx_load_ir", dx_ir, 32'hAAAA_AAAA);
        dx_en = 0; dx_bubble = 1; dx_ir_in = 32'h1; dx_a_in = 32'h2;
        step();
        chk("dx_hold_ir", dx_ir, 32'hAAAA_AAAA); chk("dx_hold_a", dx_a, 32'hAAAA_AAAA);

        // M/W load, then hold.
        mw_ir_in = 32'h4000_0000; mw_o_in = 100; mw_d_in = 42;
        step();
        chk("mw_ir", mw_ir, 32'h4000_0000); chk("mw_o", mw_o, 32'd100);
        chk("mw_d", mw_d, 32'd42);
        mw_en = 0; mw_ir_in = 32'h3; mw_o_in = 4; mw_d_in = 5;
        step();
        chk("mw_hold_o", mw_o, 32'd100);

        // Reset while D/X holds.
        reset = 1;
        step();
        chk("rst2_dx_ir", dx_ir, 32'h0); chk("rst2_dx_pc", dx_pc, 32'h0);
        chk("rst2_dx_a", dx_a, 32'h0);   chk("rst2_dx_b", dx_b, 32'h0);
        chk("rst2_fd_ir", fd_ir, 32'h0); chk("rst2_mw_o", mw_o, 32'h0);

        // Loading resumes on the edge after deassertion.
        reset = 0; fd_en = 1; fd_ir_in = 32'h55; dx_en = 1; dx_bubble = 0; dx_ir_in = 32'h66;
        step();
        chk("resume_fd_ir", fd_ir, 32'h55); chk("resume_dx_ir", dx_ir, 32'h66);

        // Random mix of enables, bubble, inputs and occasional reset; model checks each cycle.
        for (int k = 0; k < 60; k++) begin
            fd_ir_in = $urandom; fd_pc_in = $urandom;
            dx_ir_in = $urandom; dx_pc_in = $urandom; dx_a_in = $urandom; dx_b_in = $urandom;
            mw_ir_in = $urandom; mw_o_in = $urandom; mw_d_in = $urandom;
            fd_en = 1'($urandom_range(0, 1)); dx_en = 1'($urandom_range(0, 1));
            mw_en = 1'($urandom_range(0, 1)); dx_bubble = 1'($urandom_range(0, 1));
            reset = ($urandom_range(0, 15) == 0);
            step();
        end

        reset = 0;
        @(negedge clock);
        #1;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
